// File: rtl/tlb_op_if.sv
// ============================================================================
//  Module      : tlb_op_if
//  Description : Bundle of the WB-side op request, the CP0 MTC0/MFC0 access
//                and the TLB search/read/write ports seen by tlb_op_unit.
//                master = the TLB op unit, slave = its surroundings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tlb_op_if #(
  parameter int TLBNUM = 16
);
  localparam int IW = $clog2(TLBNUM);

  // WB op request
  logic          op_valid;
  logic [1:0]    op_code;
  logic          op_ready;
  logic          op_done;

  // CP0 access
  logic          cp0_we;
  logic [7:0]    cp0_waddr;
  logic [31:0]   cp0_wdata;
  logic [7:0]    cp0_raddr;
  logic [31:0]   cp0_rdata;

  // TLB search port 1
  logic [18:0]   s1_vpn2;
  logic          s1_odd_page;
  logic [7:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;

  // TLB read port
  logic [IW-1:0] r_index;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic          r_g;
  logic [19:0]   r_pfn0;
  logic [2:0]    r_c0;
  logic          r_d0;
  logic          r_v0;
  logic [19:0]   r_pfn1;
  logic [2:0]    r_c1;
  logic          r_d1;
  logic          r_v1;

  // TLB write port
  logic          we;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic          w_g;
  logic [19:0]   w_pfn0;
  logic [2:0]    w_c0;
  logic          w_d0;
  logic          w_v0;
  logic [19:0]   w_pfn1;
  logic [2:0]    w_c1;
  logic          w_d1;
  logic          w_v1;

  modport master (
    input  op_valid, op_code, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
           s1_found, s1_index,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    output op_ready, op_done, cp0_rdata,
           s1_vpn2, s1_odd_page, s1_asid, r_index,
           we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
           w_pfn1, w_c1, w_d1, w_v1
  );

  modport slave (
    output op_valid, op_code, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
           s1_found, s1_index,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
    input  op_ready, op_done, cp0_rdata,
           s1_vpn2, s1_odd_page, s1_asid, r_index,
           we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
           w_pfn1, w_c1, w_d1, w_v1
  );
endinterface

`default_nettype wire

// File: rtl/tlb_op_unit.sv
// ============================================================================
//  Module      : tlb_op_unit
//  Description : CP0 sequencer owning Index, EntryHi, EntryLo0 and EntryLo1.
//                Runs TLBP / TLBR / TLBWI against the TLB ports and captures
//                the results into those registers. IDLE -> EXEC -> DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_op_unit #(
  parameter int TLBNUM = 16
) (
  input  wire logic clk,
  input  wire logic reset,
  tlb_op_if.master  bus
);

  localparam int IW = $clog2(TLBNUM);

  localparam logic [7:0] c_ADDR_INDEX = 8'h00;
  localparam logic [7:0] c_ADDR_LO0   = 8'h10;
  localparam logic [7:0] c_ADDR_LO1   = 8'h18;
  localparam logic [7:0] c_ADDR_HI    = 8'h50;

  localparam logic [1:0] c_OP_TLBP  = 2'b01;
  localparam logic [1:0] c_OP_TLBR  = 2'b10;
  localparam logic [1:0] c_OP_TLBWI = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_op;
  logic          r_we;
  logic          r_done;

  // CP0 register fields
  logic          r_idx_p;
  logic [IW-1:0] r_idx;
  logic [18:0]   r_hi_vpn2;
  logic [7:0]    r_hi_asid;
  logic [19:0]   r_lo0_pfn;
  logic [2:0]    r_lo0_c;
  logic          r_lo0_d;
  logic          r_lo0_v;
  logic          r_lo0_g;
  logic [19:0]   r_lo1_pfn;
  logic [2:0]    r_lo1_c;
  logic          r_lo1_d;
  logic          r_lo1_v;
  logic          r_lo1_g;

  logic [31:0]   w_index_reg;
  logic [31:0]   w_hi_reg;
  logic [31:0]   w_lo0_reg;
  logic [31:0]   w_lo1_reg;
  logic          w_exec;
  logic          w_unused;

  assign w_exec = (r_state == S_EXEC);

  // Sequencer: accept in IDLE, one EXEC cycle, one DONE cycle; we/op_done are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.op_valid) begin
            r_state <= S_EXEC;
            r_op    <= bus.op_code;
            r_we    <= (bus.op_code == c_OP_TLBWI);
          end
        end
        S_EXEC: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // CP0 registers: MTC0 first, then the EXEC result so it wins on the same register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx_p   <= 1'b0;
      r_idx     <= '0;
      r_hi_vpn2 <= '0;
      r_hi_asid <= '0;
      r_lo0_pfn <= '0;
      r_lo0_c   <= '0;
      r_lo0_d   <= 1'b0;
      r_lo0_v   <= 1'b0;
      r_lo0_g   <= 1'b0;
      r_lo1_pfn <= '0;
      r_lo1_c   <= '0;
      r_lo1_d   <= 1'b0;
      r_lo1_v   <= 1'b0;
      r_lo1_g   <= 1'b0;
    end else begin
      if (bus.cp0_we) begin
        case (bus.cp0_waddr)
          c_ADDR_INDEX: r_idx <= bus.cp0_wdata[IW-1:0];
          c_ADDR_HI: begin
            r_hi_vpn2 <= bus.cp0_wdata[31:13];
            r_hi_asid <= bus.cp0_wdata[7:0];
          end
          c_ADDR_LO0: begin
            r_lo0_pfn <= bus.cp0_wdata[25:6];
            r_lo0_c   <= bus.cp0_wdata[5:3];
            r_lo0_d   <= bus.cp0_wdata[2];
            r_lo0_v   <= bus.cp0_wdata[1];
            r_lo0_g   <= bus.cp0_wdata[0];
          end
          c_ADDR_LO1: begin
            r_lo1_pfn <= bus.cp0_wdata[25:6];
            r_lo1_c   <= bus.cp0_wdata[5:3];
            r_lo1_d   <= bus.cp0_wdata[2];
            r_lo1_v   <= bus.cp0_wdata[1];
            r_lo1_g   <= bus.cp0_wdata[0];
          end
          default: ;
        endcase
      end
      if (w_exec) begin
        case (r_op)
          c_OP_TLBP: begin
            if (bus.s1_found) begin
              r_idx_p <= 1'b0;
              r_idx   <= bus.s1_index;
            end else begin
              // A miss keeps the old idx, overriding any same-cycle MTC0 Index
              r_idx_p <= 1'b1;
              r_idx   <= r_idx;
            end
          end
          c_OP_TLBR: begin
            r_hi_vpn2 <= bus.r_vpn2;
            r_hi_asid <= bus.r_asid;
            r_lo0_pfn <= bus.r_pfn0;
            r_lo0_c   <= bus.r_c0;
            r_lo0_d   <= bus.r_d0;
            r_lo0_v   <= bus.r_v0;
            r_lo0_g   <= bus.r_g;
            r_lo1_pfn <= bus.r_pfn1;
            r_lo1_c   <= bus.r_c1;
            r_lo1_d   <= bus.r_d1;
            r_lo1_v   <= bus.r_v1;
            r_lo1_g   <= bus.r_g;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_index_reg = {r_idx_p, {(31-IW){1'b0}}, r_idx};
  assign w_hi_reg    = {r_hi_vpn2, 5'b0, r_hi_asid};
  assign w_lo0_reg   = {6'b0, r_lo0_pfn, r_lo0_c, r_lo0_d, r_lo0_v, r_lo0_g};
  assign w_lo1_reg   = {6'b0, r_lo1_pfn, r_lo1_c, r_lo1_d, r_lo1_v, r_lo1_g};

  // MFC0 read mux; unmapped addresses read zero
  always_comb begin
    bus.cp0_rdata = 32'h0;
    case (bus.cp0_raddr)
      c_ADDR_INDEX: bus.cp0_rdata = w_index_reg;
      c_ADDR_HI:    bus.cp0_rdata = w_hi_reg;
      c_ADDR_LO0:   bus.cp0_rdata = w_lo0_reg;
      c_ADDR_LO1:   bus.cp0_rdata = w_lo1_reg;
      default:      bus.cp0_rdata = 32'h0;
    endcase
  end

  // Handshake; the pulses are killed during the reset cycle itself
  assign bus.op_ready = (r_state == S_IDLE);
  assign bus.op_done  = r_done & ~reset;
  assign bus.we       = r_we & ~reset;

  // Search key, read index and write data track the registers continuously
  assign bus.s1_vpn2     = r_hi_vpn2;
  assign bus.s1_asid     = r_hi_asid;
  assign bus.s1_odd_page = 1'b0;
  assign bus.r_index     = r_idx;
  assign bus.w_index     = r_idx;
  assign bus.w_vpn2      = r_hi_vpn2;
  assign bus.w_asid      = r_hi_asid;
  assign bus.w_g         = r_lo0_g & r_lo1_g;
  assign bus.w_pfn0      = r_lo0_pfn;
  assign bus.w_c0        = r_lo0_c;
  assign bus.w_d0        = r_lo0_d;
  assign bus.w_v0        = r_lo0_v;
  assign bus.w_pfn1      = r_lo1_pfn;
  assign bus.w_c1        = r_lo1_c;
  assign bus.w_d1        = r_lo1_d;
  assign bus.w_v1        = r_lo1_v;

  // EntryHi bits 12:8 are not stored
  assign w_unused = ^bus.cp0_wdata[12:8];

endmodule

`default_nettype wire

// File: tb/tb_tlb_op_unit.sv
// ============================================================================
//  Module      : tb_tlb_op_unit
//  Description : Self-checking bench for tlb_op_unit: vector table of ops
//                with a scoreboard of expected CP0 state, plus hand-written
//                back-to-back, MTC0-collision and reset-in-EXEC sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tlb_op_unit;

  localparam logic [7:0] c_A_IDX = 8'h00;
  localparam logic [7:0] c_A_LO0 = 8'h10;
  localparam logic [7:0] c_A_LO1 = 8'h18;
  localparam logic [7:0] c_A_HI  = 8'h50;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  tlb_op_if #(.TLBNUM(16)) bus ();

  tlb_op_unit #(.TLBNUM(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] pre_hi, pre_lo0, pre_lo1, pre_idx;
    logic        found;
    logic [3:0]  sidx;
    logic [18:0] rvpn2;
    logic [7:0]  rasid;
    logic        rg;
    logic [19:0] rpfn0, rpfn1;
    logic [2:0]  rc0, rc1;
    logic        rd0, rv0, rd1, rv1;
    logic [31:0] e_idx, e_hi, e_lo0, e_lo1;
  } vec_t;

  typedef struct {
    logic [31:0] idx, hi, lo0, lo1;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = a;
    bus.cp0_wdata = d;
    tick();
    bus.cp0_we    = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
    bus.cp0_raddr = a;
    #1;
    chk(name, bus.cp0_rdata, exp);
  endtask

  task automatic set_tlb(input vec_t v);
    bus.s1_found = v.found; bus.s1_index = v.sidx;
    bus.r_vpn2 = v.rvpn2; bus.r_asid = v.rasid; bus.r_g = v.rg;
    bus.r_pfn0 = v.rpfn0; bus.r_c0 = v.rc0; bus.r_d0 = v.rd0; bus.r_v0 = v.rv0;
    bus.r_pfn1 = v.rpfn1; bus.r_c1 = v.rc1; bus.r_d1 = v.rd1; bus.r_v1 = v.rv1;
  endtask

  // Issue one op from the table, check EXEC-cycle port activity, then score on op_done
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    int   cyc;
    mtc0(c_A_HI,  v.pre_hi);
    mtc0(c_A_LO0, v.pre_lo0);
    mtc0(c_A_LO1, v.pre_lo1);
    mtc0(c_A_IDX, v.pre_idx);
    set_tlb(v);
    e.idx = v.e_idx; e.hi = v.e_hi; e.lo0 = v.e_lo0; e.lo1 = v.e_lo1;
    sb.push_back(e);
    chk("ready_before_op", bus.op_ready, 1);
    bus.op_valid = 1'b1;
    bus.op_code  = v.code;
    tick();
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    // EXEC cycle
    chk("ready_in_exec", bus.op_ready, 0);
    chk("we_in_exec", bus.we, (v.code == 2'b11) ? 1 : 0);
    chk("done_in_exec", bus.op_done, 0);
    if (v.code == 2'b11) begin
      chk("w_index", bus.w_index, v.pre_idx[3:0]);
      chk("w_vpn2",  bus.w_vpn2,  v.pre_hi[31:13]);
      chk("w_asid",  bus.w_asid,  v.pre_hi[7:0]);
      chk("w_pfn0",  bus.w_pfn0,  v.pre_lo0[25:6]);
      chk("w_pfn1",  bus.w_pfn1,  v.pre_lo1[25:6]);
      chk("w_c0",    bus.w_c0,    v.pre_lo0[5:3]);
      chk("w_d1",    bus.w_d1,    v.pre_lo1[2]);
      chk("w_g",     bus.w_g,     v.pre_lo0[0] & v.pre_lo1[0]);
    end
    if (v.code == 2'b01) begin
      chk("s1_vpn2", bus.s1_vpn2, v.pre_hi[31:13]);
      chk("s1_asid", bus.s1_asid, v.pre_hi[7:0]);
      chk("s1_odd",  bus.s1_odd_page, 0);
    end
    if (v.code == 2'b10)
      chk("r_index", bus.r_index, v.pre_idx[3:0]);
    cyc = 0;
    while (!bus.op_done && cyc < 4) begin
      tick();
      cyc++;
    end
    if (!bus.op_done) begin
      chk("op_done_timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      chk("done_latency", cyc, 1);
      chk("we_in_done", bus.we, 0);
      got = sb.pop_front();
      rd("index", c_A_IDX, got.idx);
      rd("entryhi", c_A_HI, got.hi);
      rd("entrylo0", c_A_LO0, got.lo0);
      rd("entrylo1", c_A_LO1, got.lo1);
    end
    tick();
    chk("ready_after_done", bus.op_ready, 1);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    clk = 1'b0; reset = 1'b1;
    bus.op_valid = 0; bus.op_code = 0;
    bus.cp0_we = 0; bus.cp0_waddr = 0; bus.cp0_wdata = 0; bus.cp0_raddr = 0;
    bus.s1_found = 0; bus.s1_index = 0;
    bus.r_vpn2 = 0; bus.r_asid = 0; bus.r_g = 0;
    bus.r_pfn0 = 0; bus.r_c0 = 0; bus.r_d0 = 0; bus.r_v0 = 0;
    bus.r_pfn1 = 0; bus.r_c1 = 0; bus.r_d1 = 0; bus.r_v1 = 0;

    // Vector table
    for (int i = 0; i < 6; i++) vecs[i] = '{default: '0};
    // TLBWI with the canonical register image
    vecs[0].code = 2'b11; vecs[0].pre_hi = 32'h0000_2005; vecs[0].pre_lo0 = 32'h47;
    vecs[0].pre_lo1 = 32'h87; vecs[0].pre_idx = 32'd3;
    vecs[0].e_idx = 32'h3; vecs[0].e_hi = 32'h2005; vecs[0].e_lo0 = 32'h47; vecs[0].e_lo1 = 32'h87;
    // TLBP hit at index 3
    vecs[1].code = 2'b01; vecs[1].pre_hi = 32'h0000_2005; vecs[1].pre_lo0 = 32'h47;
    vecs[1].pre_lo1 = 32'h87; vecs[1].pre_idx = 32'd0; vecs[1].found = 1; vecs[1].sidx = 4'd3;
    vecs[1].e_idx = 32'h3; vecs[1].e_hi = 32'h2005; vecs[1].e_lo0 = 32'h47; vecs[1].e_lo1 = 32'h87;
    // TLBP miss: P set, idx kept
    vecs[2].code = 2'b01; vecs[2].pre_hi = 32'h0000_2005; vecs[2].pre_lo0 = 32'h47;
    vecs[2].pre_lo1 = 32'h87; vecs[2].pre_idx = 32'd7; vecs[2].found = 0; vecs[2].sidx = 4'hC;
    vecs[2].e_idx = 32'h8000_0007; vecs[2].e_hi = 32'h2005; vecs[2].e_lo0 = 32'h47; vecs[2].e_lo1 = 32'h87;
    // TLBR of entry 9 (P still set from the miss)
    vecs[3].code = 2'b10; vecs[3].pre_hi = 32'h0000_2005; vecs[3].pre_lo0 = 32'h47;
    vecs[3].pre_lo1 = 32'h87; vecs[3].pre_idx = 32'd9;
    vecs[3].rvpn2 = 19'h7ffff; vecs[3].rasid = 8'hAA; vecs[3].rg = 0;
    vecs[3].rpfn0 = 20'h0000A; vecs[3].rc0 = 3'd2; vecs[3].rd0 = 0; vecs[3].rv0 = 1;
    vecs[3].rpfn1 = 20'h12345; vecs[3].rc1 = 3'd3; vecs[3].rd1 = 1; vecs[3].rv1 = 1;
    vecs[3].e_idx = 32'h8000_0009; vecs[3].e_hi = 32'hFFFF_E0AA;
    vecs[3].e_lo0 = 32'h0000_0292; vecs[3].e_lo1 = 32'h0048_D15E;
    // NOP with a live-looking TLB: nothing changes; also checks field masking on MTC0
    vecs[4].code = 2'b00; vecs[4].pre_hi = 32'h1234_5678; vecs[4].pre_lo0 = 32'hFFFF_FFFF;
    vecs[4].pre_lo1 = 32'h0; vecs[4].pre_idx = 32'hFFFF_FFF5; vecs[4].found = 1; vecs[4].sidx = 4'hE;
    vecs[4].rvpn2 = 19'h55555; vecs[4].rasid = 8'h33; vecs[4].rpfn0 = 20'hABCDE;
    vecs[4].e_idx = 32'h8000_0005; vecs[4].e_hi = 32'h1234_4078;
    vecs[4].e_lo0 = 32'h03FF_FFFF; vecs[4].e_lo1 = 32'h0;
    // TLBWI with G set on only one half -> w_g = 0
    vecs[5].code = 2'b11; vecs[5].pre_hi = 32'hFFFF_FFFF; vecs[5].pre_lo0 = 32'h41;
    vecs[5].pre_lo1 = 32'h40; vecs[5].pre_idx = 32'hA;
    vecs[5].e_idx = 32'h8000_000A; vecs[5].e_hi = 32'hFFFF_E0FF; vecs[5].e_lo0 = 32'h41; vecs[5].e_lo1 = 32'h40;

    // Reset state
    tick(); tick();
    chk("rst_ready", bus.op_ready, 1);
    chk("rst_done", bus.op_done, 0);
    chk("rst_we", bus.we, 0);
    rd("rst_index", c_A_IDX, 32'h0);
    rd("rst_hi", c_A_HI, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Unmapped address: write ignored, reads zero
    mtc0(8'h20, 32'hDEAD_BEEF);
    rd("unmapped_rd", 8'h20, 32'h0);
    rd("unmapped_no_side", c_A_HI, 32'hFFFF_E0FF);
    tick();

    // Back-to-back requests with same-cycle MTC0 collisions
    bus.s1_found = 1; bus.s1_index = 4'd5;
    bus.op_valid = 1; bus.op_code = 2'b01;
    tick();                                   // T+1: EXEC
    chk("b2b_ready_t1", bus.op_ready, 0);
    bus.cp0_we = 1; bus.cp0_waddr = c_A_IDX; bus.cp0_wdata = 32'd2;
    tick();                                   // T+2: DONE
    bus.cp0_we = 0;
    chk("b2b_done_t2", bus.op_done, 1);
    chk("b2b_ready_t2", bus.op_ready, 0);
    rd("collide_index", c_A_IDX, 32'h5);
    bus.s1_found = 0; bus.s1_index = 4'd9;
    tick();                                   // T+3: IDLE, second accepted
    chk("b2b_ready_t3", bus.op_ready, 1);
    chk("b2b_done_t3", bus.op_done, 0);
    tick();                                   // T+4: second EXEC
    chk("b2b_ready_t4", bus.op_ready, 0);
    bus.cp0_we = 1; bus.cp0_waddr = c_A_LO1; bus.cp0_wdata = 32'h87;
    tick();                                   // T+5: second DONE
    bus.cp0_we = 0;
    bus.op_valid = 0;
    chk("b2b_done_t5", bus.op_done, 1);
    rd("miss_index", c_A_IDX, 32'h8000_0005);
    rd("other_reg_mtc0", c_A_LO1, 32'h87);
    tick();
    chk("b2b_ready_end", bus.op_ready, 1);

    // Reset asserted during TLBWI EXEC
    bus.op_valid = 1; bus.op_code = 2'b11;
    tick();
    bus.op_valid = 0;
    chk("rexec_we_before", bus.we, 1);
    reset = 1'b1;
    #1;
    chk("rexec_we_forced", bus.we, 0);
    chk("rexec_done_forced", bus.op_done, 0);
    tick();
    reset = 1'b0;
    chk("rexec_ready", bus.op_ready, 1);
    chk("rexec_we_after", bus.we, 0);
    rd("rexec_index", c_A_IDX, 32'h0);
    rd("rexec_hi", c_A_HI, 32'h0);
    rd("rexec_lo0", c_A_LO0, 32'h0);
    rd("rexec_lo1", c_A_LO1, 32'h0);
    tick();
    chk("rexec_no_done", bus.op_done, 0);
    chk("rexec_ready2", bus.op_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
